// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC bus scheduler and its bus engine.
package rtc_pkg;

    localparam int unsigned NSLOT = 11;
    localparam int unsigned IDX_W = 4;
    localparam logic [7:0]  TRANSFER_CMD = 8'hF0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_A_ACT,
        ST_A_GAP,
        ST_D_ACT,
        ST_D_GAP
    } phy_state_t;

    typedef enum logic [1:0] {
        TX_CMD,
        TX_RD,
        TX_WR
    } txn_kind_t;

    typedef struct packed {
        txn_kind_t        kind;
        logic [7:0]       addr;
        logic [7:0]       data;
        logic [IDX_W-1:0] tag;
        logic             last;
    } txn_t;

    // Sweep slot 0 is the LSB entry: sec, min, hour, date, month, year, dow, week, timer s/m/h
    localparam logic [NSLOT-1:0][7:0] SLOT_ADDR = {
        8'h43, 8'h42, 8'h41, 8'h28, 8'h27, 8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21
    };

    function automatic logic [7:0] slot_addr(input logic [IDX_W-1:0] idx);
        return (idx < IDX_W'(NSLOT)) ? SLOT_ADDR[idx] : 8'h00;
    endfunction

endpackage

// File: rtl/rtc_bus_phy.sv
// Runs one CMD/RD/WR transaction on the multiplexed RTC bus; all strobes active-low.
module rtc_bus_phy
    import rtc_pkg::*;
#(
    parameter int unsigned PHASE_CYC = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       kind,
    input  logic [7:0]       addr,
    input  logic [7:0]       data,
    input  logic [IDX_W-1:0] tag,
    input  logic             last,
    output logic             busy,
    output logic             wack,
    output logic             rvalid,
    output logic             rlast,
    output logic [IDX_W-1:0] rtag,
    output logic [7:0]       rdata,
    inout  wire  [7:0]       bus,
    output logic             chip_select,
    output logic             read_strobe,
    output logic             write_strobe,
    output logic             aod
);

    localparam int unsigned     CNT_W    = $clog2(PHASE_CYC);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PHASE_CYC - 1);

    phy_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    txn_t             cur, cur_nxt;
    logic             phase_end;
    logic             drive, drive_nxt;
    logic [7:0]       dout, dout_nxt;
    logic             busy_nxt, cs_nxt, rds_nxt, wrs_nxt, aod_nxt;
    logic             wack_nxt, rvalid_nxt, rlast_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cur_nxt   = cur;
        phase_end = (cnt == '0);
        case (state)
            ST_IDLE: if (start) begin
                state_nxt    = ST_A_ACT;
                cur_nxt.kind = txn_kind_t'(kind);
                cur_nxt.addr = addr;
                cur_nxt.data = data;
                cur_nxt.tag  = tag;
                cur_nxt.last = last;
            end
            ST_A_ACT: if (phase_end) state_nxt = ST_A_GAP;
            ST_A_GAP: if (phase_end) state_nxt = (cur.kind == TX_CMD) ? ST_IDLE : ST_D_ACT;
            ST_D_ACT: if (phase_end) state_nxt = ST_D_GAP;
            ST_D_GAP: if (phase_end) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (state_nxt != state) begin
            cnt_nxt = CNT_LOAD;
        end else if (state != ST_IDLE) begin
            cnt_nxt = cnt - CNT_W'(1);
        end

        // Outputs are decoded from the next state so the registered pins line up with the state
        busy_nxt   = (state_nxt != ST_IDLE);
        cs_nxt     = !(state_nxt == ST_A_ACT || state_nxt == ST_D_ACT);
        aod_nxt    = (state_nxt != ST_A_ACT);
        rds_nxt    = !(state_nxt == ST_D_ACT && cur_nxt.kind == TX_RD);
        wrs_nxt    = !(state_nxt == ST_A_ACT || (state_nxt == ST_D_ACT && cur_nxt.kind == TX_WR));
        drive_nxt  = (state_nxt == ST_A_ACT) || (state_nxt == ST_D_ACT && cur_nxt.kind == TX_WR);
        dout_nxt   = (state_nxt == ST_A_ACT) ? cur_nxt.addr : cur_nxt.data;
        wack_nxt   = (state_nxt == ST_D_GAP) && (cnt_nxt == '0) && (cur_nxt.kind == TX_WR);
        rvalid_nxt = (state == ST_D_ACT) && phase_end && (cur.kind == TX_RD);
        rlast_nxt  = rvalid_nxt && cur.last;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            cur          <= '0;
            drive        <= 1'b0;
            dout         <= 8'h00;
            busy         <= 1'b0;
            chip_select  <= 1'b1;
            read_strobe  <= 1'b1;
            write_strobe <= 1'b1;
            aod          <= 1'b1;
            wack         <= 1'b0;
            rvalid       <= 1'b0;
            rlast        <= 1'b0;
            rtag         <= '0;
            rdata        <= 8'h00;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            cur          <= cur_nxt;
            drive        <= drive_nxt;
            dout         <= dout_nxt;
            busy         <= busy_nxt;
            chip_select  <= cs_nxt;
            read_strobe  <= rds_nxt;
            write_strobe <= wrs_nxt;
            aod          <= aod_nxt;
            wack         <= wack_nxt;
            rvalid       <= rvalid_nxt;
            rlast        <= rlast_nxt;
            if (rvalid_nxt) begin
                rtag  <= cur.tag;
                rdata <= bus;
            end
        end
    end

    assign bus = drive ? dout : 8'hzz;

endmodule

// File: rtl/rtc_bus_scheduler.sv
// Arbitrates RTC bus between periodic register sweeps and edit-machine writes.
// Define RTC_TRANSFER_CMD_EN to prefix each sweep with the 0xF0 transfer-latch command.
module rtc_bus_scheduler
    import rtc_pkg::*;
#(
    parameter int unsigned PHASE_CYC   = 10,
    parameter int unsigned REFRESH_CYC = 1_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rd_en,
    input  logic             wr_req,
    input  logic [7:0]       wr_addr,
    input  logic [7:0]       wr_data,
    output logic             wr_ack,
    output logic             rd_valid,
    output logic [IDX_W-1:0] rd_idx,
    output logic [7:0]       rd_data,
    output logic             sweep_done,
    output logic             busy,
    inout  wire  [7:0]       DATA_ADDRESS,
    output logic             ChipSelect,
    output logic             Read,
    output logic             Write,
    output logic             AoD
);

    localparam int unsigned REF_W = $clog2(REFRESH_CYC);

    logic [REF_W-1:0] ref_cnt;
    logic             wrap;
    logic             pend, pend_nxt, pend_clr;
    logic             in_sweep, in_sweep_nxt;
    logic [IDX_W-1:0] slot, slot_nxt;
    logic             start;
    txn_kind_t        kind;
    logic [7:0]       addr, data;
    logic [IDX_W-1:0] tag;
    logic             last;

    assign wrap = (ref_cnt == REF_W'(REFRESH_CYC - 1));

    // Grant decision, only while the bus engine is idle; writes first, then sweep work
    always_comb begin
        start        = 1'b0;
        kind         = TX_RD;
        addr         = 8'h00;
        data         = 8'h00;
        tag          = '0;
        last         = 1'b0;
        pend_clr     = 1'b0;
        in_sweep_nxt = in_sweep;
        slot_nxt     = slot;
        if (!busy) begin
            if (wr_req) begin
                start = 1'b1;
                kind  = TX_WR;
                addr  = wr_addr;
                data  = wr_data;
            end else if (in_sweep) begin
                start    = 1'b1;
                addr     = slot_addr(slot);
                tag      = slot;
                last     = (slot == IDX_W'(NSLOT - 1));
                slot_nxt = slot + IDX_W'(1);
                if (last) in_sweep_nxt = 1'b0;
            end else if (pend) begin
                start        = 1'b1;
                pend_clr     = 1'b1;
                in_sweep_nxt = 1'b1;
`ifdef RTC_TRANSFER_CMD_EN
                kind         = TX_CMD;
                addr         = TRANSFER_CMD;
                slot_nxt     = '0;
`else
                addr         = slot_addr('0);
                slot_nxt     = IDX_W'(1);
`endif
            end
        end
        pend_nxt = (pend && !pend_clr) || (wrap && rd_en);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ref_cnt  <= '0;
            pend     <= 1'b0;
            in_sweep <= 1'b0;
            slot     <= '0;
        end else begin
            ref_cnt  <= wrap ? '0 : ref_cnt + REF_W'(1);
            pend     <= pend_nxt;
            in_sweep <= in_sweep_nxt;
            slot     <= slot_nxt;
        end
    end

    rtc_bus_phy #(
        .PHASE_CYC(PHASE_CYC)
    ) u_phy (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .kind        (kind),
        .addr        (addr),
        .data        (data),
        .tag         (tag),
        .last        (last),
        .busy        (busy),
        .wack        (wr_ack),
        .rvalid      (rd_valid),
        .rlast       (sweep_done),
        .rtag        (rd_idx),
        .rdata       (rd_data),
        .bus         (DATA_ADDRESS),
        .chip_select (ChipSelect),
        .read_strobe (Read),
        .write_strobe(Write),
        .aod         (AoD)
    );

endmodule

// File: doc/rtc_bus_scheduler.md
# rtc_bus_scheduler

Owns the multiplexed 8-bit address/data bus to the external RTC. It sequences periodic read sweeps of all eleven time/timer registers and shares the bus with write requests from the edit state machines. It sits between the register-editing logic and the RTC pins (DATA_ADDRESS, ChipSelect, Read, Write, AoD), replacing ad-hoc per-machine bus driving with one arbitrated sequencer.

## Interface
- PHASE_CYC, 10: clk cycles per bus phase (active or gap); minimum 2.
- REFRESH_CYC, 1_000_000: clk cycles between sweep starts; minimum 64*PHASE_CYC.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low; one clock domain.
- rd_en  in  1  enables periodic sweeps; 0 = no new sweeps, and any sweep in progress completes.
- wr_req  in  1  write request level; held until wr_ack.
- wr_addr  in  8  RTC register address; sampled when grant occurs.
- wr_data  in  8  write data; sampled when grant occurs.
- wr_ack  out  1  one-cycle pulse on write completion.
- rd_valid  out  1  one-cycle pulse when rd_data holds a new sweep value.
- rd_idx  out  4  sweep slot 0..10 of rd_data.
- rd_data  out  8  register value read.
- sweep_done  out  1  one-cycle pulse after slot 10 completes.
- busy  out  1  high whenever the sequencer is not in IDLE.
- DATA_ADDRESS  inout  8  multiplexed RTC bus.
- ChipSelect, Read, Write, AoD  out  1 each  RTC strobes, all active-low.

## Operation
- Sweep slot map, fixed: 0x21 sec, 0x22 min, 0x23 hour, 0x24 date, 0x25 month, 0x26 year, 0x27 day-of-week, 0x28 week number, 0x41/0x42/0x43 timer sec/min/hour → slots 0..10.
- Refresh counter: free-running; counts 0..REFRESH_CYC-1. On wrap with rd_en=1, it sets sweep_pend. sweep_pend holds at most one pending sweep, and further wraps while pending are dropped.
- Transaction types:
  - CMD: address phase only.
  - RD: address phase, then data phase with Read=0.
  - WR: address phase, then data phase with Write=0.
- FSM states: IDLE, A_ACT, A_GAP, D_ACT, D_GAP. Each state lasts exactly PHASE_CYC cycles, and a phase counter is reloaded on each entry.
- A_ACT: ChipSelect=0, Write=0, AoD=0, address driven.
- D_ACT: ChipSelect=0, AoD=1, plus Read=0 (RD) or Write=0 with data driven (WR).
- Gaps: all strobes 1, bus hi-Z.
- CMD ends at A_GAP→IDLE. RD and WR end at D_GAP→IDLE.
- Arbitration happens only in IDLE. A pending wr_req has priority over sweep continuation or start.
- A sweep holds its slot index across an inserted write, then resumes at the next slot. Writes are therefore interleaved between slots, never inside a transaction.
- A sweep begins with CMD 0xF0 (transfer latch) when the RTC_TRANSFER_CMD_EN macro is defined; otherwise it begins directly at slot 0. sweep_pend clears when the sweep begins.
- DATA_ADDRESS is driven only in A_ACT and in D_ACT of WR; otherwise hi-Z.
- Reset (reset=0 at a clk edge) forces the following state, from the next cycle:
  - State IDLE, all strobes 1, bus hi-Z.
  - rd_data=0, rd_idx=0, rd_valid=0, wr_ack=0, sweep_done=0, busy=0.
  - sweep_pend=0, refresh counter=0.
  - Applies mid-transaction with no completion pulses.

## Timing
- P = PHASE_CYC.
- RD/WR transaction: 4P cycles. CMD: 2P cycles.
- Full sweep: 44P cycles, plus 2P with the transfer command.
- RD sampling: DATA_ADDRESS is sampled on the last cycle of D_ACT. rd_data and rd_idx update, and rd_valid pulses, on the first D_GAP cycle.
- wr_ack pulses on the last D_GAP cycle.
- A requester must not drop wr_req before wr_ack. If wr_req is still high in the IDLE cycle after wr_ack, a new write is granted.
- Grant latency from wr_req rise in IDLE: 1 cycle to A_ACT. Worst case while a sweep transaction is active: 4P+1 cycles.
- sweep_done pulses in the same cycle as the slot-10 rd_valid.
- rd_en falling mid-sweep does not abort the sweep.

## Configuration
- RTC_TRANSFER_CMD_EN defined: each sweep is prefixed by CMD 0xF0, so all slots come from one latched RTC snapshot.
- RTC_TRANSFER_CMD_EN undefined: no CMD transaction is issued, and the sweep starts at slot 0.

## Structure
- Package rtc_pkg holds:
  - FSM state encoding.
  - Transaction-type encoding (CMD/RD/WR).
  - The 11-entry slot-address table.
  - TRANSFER_CMD = 8'hF0.
  - NSLOT = 11.
- One sub-module, rtc_bus_phy: takes a single transaction (type, addr, data, start) and runs the five states. It handles strobes and the tristate, and returns done and rdata. rtc_bus_scheduler keeps the refresh counter, sweep index, and arbitration.

## Test plan
- Bench parameters: PHASE_CYC=2, REFRESH_CYC=200, macro defined, RTC model returns (addr XOR 8'h5A).
- Reset then rd_en=1 → first sweep at cycle 200. CMD F0 lasts 4 cycles, then 11 RD. rd_valid shows idx0=0x7B … idx10=0x19, and sweep_done arrives 92 cycles after the sweep starts.
- wr_req with addr 0x22, data 0x45 in IDLE → A_ACT next cycle, Write=0 in both phases, bus=0x45 in D_ACT, wr_ack 8 cycles after grant.
- wr_req raised during slot 3 RD → slot 3 completes, write inserted, slot 4 follows, sweep_done still reached.
- rd_en held 1 with write traffic spanning two refresh wraps → exactly one extra sweep runs afterward.
- reset=0 during D_ACT of a WR → next cycle all strobes 1, bus hi-Z, no wr_ack, busy=0.
- Rebuild with macro undefined → first transaction of a sweep is RD 0x21, sweep length 88 cycles.
